// File: rtl/temporal_mxu_tiled_if.sv
// Operand/result bundle for temporal_mxu_tiled: start/accumulate request side,
// operand matrices, and the valid/ready result side.
interface temporal_mxu_tiled_if #(
  parameter int BIT_WIDTH = 4,
  parameter int M         = 2,
  parameter int K         = 2,
  parameter int N         = 2
);
  localparam int OUT_W = (K == 1) ? 2*BIT_WIDTH + 1 : 2*BIT_WIDTH + $clog2(K);

  logic                                start;
  logic                                accumulate;
  logic [M-1:0][K-1:0][BIT_WIDTH-1:0]  A;
  logic [K-1:0][N-1:0][BIT_WIDTH-1:0]  B;
  logic                                busy;
  logic                                out_valid;
  logic                                out_ready;
  logic [M-1:0][N-1:0][OUT_W-1:0]      out;

  modport master (
    output start, accumulate, A, B, out_ready,
    input  busy, out_valid, out
  );

  modport slave (
    input  start, accumulate, A, B, out_ready,
    output busy, out_valid, out
  );
endinterface

// File: rtl/temporal_mxu_tiled.sv
// Unary-time M x K by K x N matrix multiply with tile accumulation and a
// valid/ready result; define TEMPORAL_MXU_EARLY_EXIT_EN to stop at max(A).
module temporal_mxu_tiled #(
  parameter int BIT_WIDTH = 4,
  parameter int M         = 2,
  parameter int K         = 2,
  parameter int N         = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  temporal_mxu_tiled_if.slave bus
);
  localparam int OUT_W = (K == 1) ? 2*BIT_WIDTH + 1 : 2*BIT_WIDTH + $clog2(K);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [M-1:0][K-1:0][BIT_WIDTH-1:0] a_mat_t;
  typedef logic [K-1:0][N-1:0][BIT_WIDTH-1:0] b_mat_t;
  typedef logic [M-1:0][N-1:0][OUT_W-1:0]     c_mat_t;

  state_t               state_q, state_d;
  logic [BIT_WIDTH-1:0] t_q, t_d, last_t;
  a_mat_t               a_q, a_d;
  b_mat_t               b_q, b_d;
  c_mat_t               acc_q, acc_d, step;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 accept;

  // One unary time slot: B contributes while t is still below the A count.
  function automatic logic [OUT_W-1:0] gated_term(input logic [BIT_WIDTH-1:0] t,
                                                  input logic [BIT_WIDTH-1:0] a,
                                                  input logic [BIT_WIDTH-1:0] b);
    return (t < a) ? OUT_W'(b) : '0;
  endfunction

`ifdef TEMPORAL_MXU_EARLY_EXIT_EN
  logic [BIT_WIDTH-1:0] run_len_q, run_len_d, max_a;

  always_comb begin
    max_a = '0;
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++)
        if (bus.A[i][k] > max_a) max_a = bus.A[i][k];
  end

  assign last_t = run_len_q - BIT_WIDTH'(1);
`else
  // The slot t = 2^W - 1 can never satisfy t < A, so the run stops one short.
  assign last_t = BIT_WIDTH'((1 << BIT_WIDTH) - 2);
`endif

  always_comb begin
    step = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < K; k++)
          step[i][j] = step[i][j] + gated_term(t_q, a_q[i][k], b_q[k][j]);
  end

  assign accept = bus.start && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    valid_d = valid_q;
`ifdef TEMPORAL_MXU_EARLY_EXIT_EN
    run_len_d = run_len_q;
`endif
    case (state_q)
      RUN: begin
        for (int i = 0; i < M; i++)
          for (int j = 0; j < N; j++)
            acc_d[i][j] = acc_q[i][j] + step[i][j];
        t_d = t_q + BIT_WIDTH'(1);
        if (t_q == last_t) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    // A new run overrides the DONE release so back-to-back starts go straight to RUN.
    if (accept) begin
      a_d     = bus.A;
      b_d     = bus.B;
      t_d     = '0;
      state_d = RUN;
      busy_d  = 1'b1;
      valid_d = 1'b0;
      if (!bus.accumulate) acc_d = '0;
`ifdef TEMPORAL_MXU_EARLY_EXIT_EN
      run_len_d = (max_a == '0) ? BIT_WIDTH'(1) : max_a;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef TEMPORAL_MXU_EARLY_EXIT_EN
      run_len_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
`ifdef TEMPORAL_MXU_EARLY_EXIT_EN
      run_len_q <= run_len_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = valid_q;
  assign bus.out       = acc_q;
endmodule
